// File: rtl/svm_recall_sequencer.sv
// svm_recall_sequencer
// Sequential scheduler for a two-feature sign-magnitude SVM recall.
// It holds up to NUM_SV support vectors in a local register file. One
// sample is taken per valid/ready handshake. A single two-term
// sign-magnitude multiply-accumulate is then stepped across the active
// support vectors, one vector per cycle. The result is the biased score
// and its class decision.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   cfg_we/addr/wdata support-vector write port ({s1,m1[6:0],s2,m2[6:0]})
//   cfg_err          one-cycle pulse when a write is rejected
//   n_sv, bias       active SV count and signed bias, taken at acceptance
//   in_valid/ready   sample handshake carrying x1, x2 (unsigned 7-bit)
//   out_valid/ready  result handshake carrying out_score and out_class
module svm_recall_sequencer #(
    parameter int NUM_SV = 8,
    parameter int ACC_W  = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_SV):0]     cfg_addr,
    input  logic [15:0]                 cfg_wdata,
    output logic                        cfg_err,
    input  logic [$clog2(NUM_SV):0]     n_sv,
    input  logic [15:0]                 bias,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [6:0]                  x1,
    input  logic [6:0]                  x2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_W-1:0]     out_score,
    output logic                        out_class
);

    localparam int AW = $clog2(NUM_SV) + 1;
    localparam int SW = $clog2(NUM_SV);
    localparam logic [AW-1:0] NUM_SV_W = AW'(NUM_SV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, next_state;

    logic [15:0]              sv_mem [NUM_SV];
    logic [6:0]               x1_q, x2_q;
    logic [AW-1:0]            n_q;
    logic [AW-1:0]            idx;
    logic signed [ACC_W-1:0]  acc;

    logic                     accept;
    logic                     cfg_ok;
    logic [AW-1:0]            n_eff;
    logic [15:0]              sv_word;
    logic [13:0]              prod1, prod2;
    logic signed [ACC_W-1:0]  ext1, ext2, term;

    assign accept = in_valid && in_ready;
    assign cfg_ok = cfg_we && (state == IDLE) && (cfg_addr < NUM_SV_W);
    assign n_eff  = (n_sv > NUM_SV_W) ? NUM_SV_W : n_sv;

    // One term per cycle: magnitudes are multiplied unsigned, then the
    // sign bits pick add or subtract. A negated zero is still zero.
    assign sv_word = sv_mem[idx[SW-1:0]];
    assign prod1   = {7'b0, x1_q} * {7'b0, sv_word[14:8]};
    assign prod2   = {7'b0, x2_q} * {7'b0, sv_word[6:0]};
    assign ext1    = {{(ACC_W-14){1'b0}}, prod1};
    assign ext2    = {{(ACC_W-14){1'b0}}, prod2};
    assign term    = (sv_word[15] ? -ext1 : ext1) + (sv_word[7] ? -ext2 : ext2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_score  = '0;
        out_class  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = (n_eff != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (idx == n_q - AW'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_score = acc;
                out_class = ~acc[ACC_W-1];
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A write in the acceptance cycle lands on the same edge. Slot 0 is
    // first read in the following cycle, so it sees the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SV; i++) begin
                sv_mem[i] <= 16'h0000;
            end
            x1_q    <= '0;
            x2_q    <= '0;
            n_q     <= '0;
            idx     <= '0;
            acc     <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                sv_mem[cfg_addr[SW-1:0]] <= cfg_wdata;
            end
            if (accept) begin
                x1_q <= x1;
                x2_q <= x2;
                n_q  <= n_eff;
                idx  <= '0;
                acc  <= {{(ACC_W-16){bias[15]}}, bias};
            end else if (state == ACCUM) begin
                acc <= acc + term;
                idx <= idx + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_svm_recall_sequencer.sv
// tb_svm_recall_sequencer
// Self-checking bench for svm_recall_sequencer. A behavioural model holds
// the slot contents and computes each score as a plain sum of signed
// products. Directed cases are followed by randomized runs.
module tb_svm_recall_sequencer;

    localparam int NUM_SV = 8;
    localparam int ACC_W  = 20;
    localparam int AW     = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cfg_we;
    logic [AW-1:0]           cfg_addr;
    logic [15:0]             cfg_wdata;
    logic                    cfg_err;
    logic [AW-1:0]           n_sv;
    logic [15:0]             bias;
    logic                    in_valid;
    logic                    in_ready;
    logic [6:0]              x1;
    logic [6:0]              x2;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_score;
    logic                    out_class;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] model_slots [NUM_SV];

    svm_recall_sequencer #(.NUM_SV(NUM_SV), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err),
        .n_sv      (n_sv),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_score (out_score),
        .out_class (out_class)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input longint observed, input longint expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Score = bias + sum of signed feature products over the active slots.
    function automatic longint model_score(input int n, input int b, input int a, input int c);
        longint s;
        int     nn;
        longint p1, p2;
        s  = longint'($signed(16'(b)));
        nn = (n > NUM_SV) ? NUM_SV : n;
        for (int i = 0; i < nn; i++) begin
            p1 = longint'(a) * longint'(model_slots[i][14:8]);
            p2 = longint'(c) * longint'(model_slots[i][6:0]);
            s  = s + (model_slots[i][15] ? -p1 : p1) + (model_slots[i][7] ? -p2 : p2);
        end
        return s;
    endfunction

    task automatic write_slot(input int addr, input logic [15:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(addr);
        cfg_wdata = data;
        step();
        cfg_we = 1'b0;
        check_output("cfg_err_idle_write", longint'(cfg_err), (addr >= NUM_SV) ? 1 : 0);
        if (addr < NUM_SV) model_slots[addr] = data;
        step();
        check_output("cfg_err_clears", longint'(cfg_err), 0);
    endtask

    // Runs one sample. Optionally writes slot 0 in the acceptance cycle.
    // With hold > 0, out_ready stays low for that many cycles in DONE and
    // a rejected slot-0 write is issued.
    task automatic apply_stimulus(input int n, input int b, input int a, input int c,
                                  input int hold, input bit do_wr, input logic [15:0] wd);
        longint expected;
        int     ne;
        int     cycles;
        ne = (n > NUM_SV) ? NUM_SV : n;
        check_output("in_ready_idle", longint'(in_ready), 1);
        if (do_wr) begin
            cfg_we    = 1'b1;
            cfg_addr  = '0;
            cfg_wdata = wd;
            model_slots[0] = wd;
        end
        expected = model_score(n, b, a, c);
        n_sv     = AW'(n);
        bias     = 16'(b);
        x1       = 7'(a);
        x2       = 7'(c);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        n_sv     = AW'($urandom);
        bias     = 16'($urandom);
        x1       = 7'($urandom);
        x2       = 7'($urandom);
        check_output("in_ready_busy", longint'(in_ready), 0);
        cycles = 1;
        while (out_valid !== 1'b1 && cycles < 40) begin
            step();
            cycles++;
        end
        check_output("latency", cycles, ne + 1);
        check_output("score", longint'(out_score), expected);
        check_output("class", longint'(out_class), (expected >= 0) ? 1 : 0);
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                cfg_we    = 1'b1;
                cfg_addr  = '0;
                cfg_wdata = 16'hFFFF;
            end
            step();
            cfg_we = 1'b0;
            check_output("hold_cfg_err", longint'(cfg_err), (h == 0) ? 1 : 0);
            check_output("hold_valid", longint'(out_valid), 1);
            check_output("hold_score", longint'(out_score), expected);
            check_output("hold_class", longint'(out_class), (expected >= 0) ? 1 : 0);
            check_output("hold_in_ready", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_output("valid_drop", longint'(out_valid), 0);
        check_output("in_ready_back", longint'(in_ready), 1);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        n_sv      = '0;
        bias      = '0;
        in_valid  = 1'b0;
        x1        = '0;
        x2        = '0;
        out_ready = 1'b0;
        for (int i = 0; i < NUM_SV; i++) model_slots[i] = 16'h0000;
        step();
        step();
        check_output("rst_out_valid", longint'(out_valid), 0);
        check_output("rst_out_score", longint'(out_score), 0);
        check_output("rst_out_class", longint'(out_class), 0);
        check_output("rst_cfg_err", longint'(cfg_err), 0);
        rst = 1'b0;
        step();
        check_output("rst_in_ready", longint'(in_ready), 1);

        $display("[TB] directed sign and zero-boundary cases");
        write_slot(0, 16'h0302);
        apply_stimulus(1, 0, 5, 4, 0, 1'b0, 16'h0);
        write_slot(0, 16'h8302);
        apply_stimulus(1, 0, 5, 4, 0, 1'b0, 16'h0);
        write_slot(0, 16'h0302);
        write_slot(1, 16'h8382);
        apply_stimulus(2, 0, 5, 4, 0, 1'b0, 16'h0);
        apply_stimulus(0, 16'hFFFF, 5, 4, 0, 1'b0, 16'h0);

        $display("[TB] full-scale and clamp cases");
        for (int i = 0; i < NUM_SV; i++) write_slot(i, 16'h7F7F);
        apply_stimulus(8, 32767, 127, 127, 0, 1'b0, 16'h0);
        apply_stimulus(12, 32767, 127, 127, 0, 1'b0, 16'h0);

        $display("[TB] hold in DONE with rejected writes");
        apply_stimulus(3, 100, 9, 17, 5, 1'b0, 16'h0);
        apply_stimulus(1, 0, 1, 1, 0, 1'b0, 16'h0);
        write_slot(8, 16'h1234);
        write_slot(15, 16'h1234);

        $display("[TB] write in the acceptance cycle");
        apply_stimulus(2, -50, 33, 71, 0, 1'b1, 16'h8A05);

        $display("[TB] randomized runs");
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                write_slot(int'($urandom_range(0, NUM_SV - 1)), 16'($urandom));
            end
            apply_stimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
                           int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                           int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("[TB] reset during accumulation");
        n_sv     = AW'(8);
        bias     = 16'd77;
        x1       = 7'd50;
        x2       = 7'd60;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NUM_SV; i++) model_slots[i] = 16'h0000;
        check_output("abort_out_valid", longint'(out_valid), 0);
        check_output("abort_in_ready", longint'(in_ready), 1);
        step();
        check_output("abort_no_result", longint'(out_valid), 0);
        apply_stimulus(8, 5, 100, 100, 0, 1'b0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
